// File: rtl/imm_gen_stage.sv
`default_nettype none
// ============================================================================
//  Module   : imm_gen_stage
//  Purpose  : RV32I/RV64I immediate extraction and extension, queued in a
//             small valid/ready FIFO between decode and execute.
//  Revision : 1.0  initial release
// ============================================================================
module imm_gen_stage #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rstn,
    input  logic                       flush,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [2:0]                 imm_src,
    input  logic [24:0]                instr,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [XLEN-1:0]            imm_ext,
    output logic                       imm_err,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int c_PW = $clog2(DEPTH);
    localparam int c_CW = $clog2(DEPTH + 1);
    localparam logic [c_PW-1:0] c_LAST = c_PW'(DEPTH - 1);
    localparam logic [c_CW-1:0] c_FULL = c_CW'(DEPTH);

    logic [XLEN-1:0] r_mem_imm [DEPTH];
    logic            r_mem_err [DEPTH];
    logic [c_PW-1:0] r_wr_ptr;
    logic [c_PW-1:0] r_rd_ptr;
    logic [c_CW-1:0] r_count;
    logic [XLEN-1:0] r_imm_ext;
    logic            r_imm_err;

    logic            w_push;
    logic            w_pop;
    logic [c_PW-1:0] w_wr_next;
    logic [c_PW-1:0] w_rd_next;
    logic [c_CW-1:0] w_count_next;
    logic [31:0]     w_imm32;
    logic            w_sext;
    logic [5:0]      w_shamt;
    logic [XLEN-1:0] w_ext;
    logic            w_err;

    // instr carries bits [31:7] of the instruction, so bit b sits at instr[b-7]
    generate
        if (XLEN == 64) begin : g_shamt64
            assign w_shamt = instr[18:13];
        end else begin : g_shamt32
            assign w_shamt = {1'b0, instr[17:13]};
        end
    endgenerate

    always_comb begin
        w_imm32 = '0;
        w_sext  = 1'b0;
        case (imm_src)
            3'd0: begin
                w_imm32 = {{20{instr[24]}}, instr[24:13]};
                w_sext  = 1'b1;
            end
            3'd1: begin
                w_imm32 = {{20{instr[24]}}, instr[24:18], instr[4:0]};
                w_sext  = 1'b1;
            end
            3'd2: begin
                w_imm32 = {{19{instr[24]}}, instr[24], instr[0], instr[23:18], instr[4:1], 1'b0};
                w_sext  = 1'b1;
            end
            3'd3: begin
                w_imm32 = {instr[24:5], 12'b0};
                w_sext  = 1'b1;
            end
            3'd4: begin
                w_imm32 = {{11{instr[24]}}, instr[24], instr[12:5], instr[13], instr[23:14], 1'b0};
                w_sext  = 1'b1;
            end
            3'd5:    w_imm32 = {26'b0, w_shamt};
            3'd6:    w_imm32 = {27'b0, instr[12:8]};
            default: w_imm32 = '0;
        endcase
    end

    assign w_ext = w_sext ? XLEN'($signed(w_imm32)) : XLEN'(w_imm32);
    assign w_err = (imm_src == 3'd7);

    assign in_ready  = (r_count != c_FULL);
    assign out_valid = (r_count != '0);
    assign imm_ext   = r_imm_ext;
    assign imm_err   = r_imm_err;
    assign count     = r_count;

    assign w_push    = in_valid && in_ready;
    assign w_pop     = out_valid && out_ready;
    assign w_wr_next = (r_wr_ptr == c_LAST) ? '0 : r_wr_ptr + 1'b1;
    assign w_rd_next = (r_rd_ptr == c_LAST) ? '0 : r_rd_ptr + 1'b1;

    always_comb begin
        w_count_next = r_count;
        case ({w_push, w_pop})
            2'b10:   w_count_next = r_count + 1'b1;
            2'b01:   w_count_next = r_count - 1'b1;
            default: w_count_next = r_count;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_count   <= '0;
            r_imm_ext <= '0;
            r_imm_err <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem_imm[i] <= '0;
                r_mem_err[i] <= 1'b0;
            end
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_mem_imm[r_wr_ptr] <= w_ext;
                r_mem_err[r_wr_ptr] <= w_err;
                r_wr_ptr            <= w_wr_next;
            end
            if (w_pop) begin
                r_rd_ptr <= w_rd_next;
            end
            r_count <= w_count_next;
            // Head register tracks the next entry; a new entry landing on the
            // next head slot this cycle is taken straight from the extender.
            if (w_push && (r_count == '0)) begin
                r_imm_ext <= w_ext;
                r_imm_err <= w_err;
            end else if (w_pop && (w_count_next != '0)) begin
                if (w_push && (r_wr_ptr == w_rd_next)) begin
                    r_imm_ext <= w_ext;
                    r_imm_err <= w_err;
                end else begin
                    r_imm_ext <= r_mem_imm[w_rd_next];
                    r_imm_err <= r_mem_err[w_rd_next];
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_imm_gen_stage.sv
`default_nettype none
// ============================================================================
//  Module   : tb_imm_gen_stage
//  Purpose  : Self-checking bench for imm_gen_stage (XLEN=32/DEPTH=2 and
//             XLEN=64/DEPTH=3 instances sharing one stimulus stream).
//  Revision : 1.0  initial release
// ============================================================================
module tb_imm_gen_stage;

    logic        clk;
    logic        rstn;
    logic        flush;
    logic        in_valid;
    logic [2:0]  imm_src;
    logic [31:0] ins;
    logic        out_ready;

    logic        w_rdy32, w_vld32, w_err32;
    logic [31:0] w_imm32;
    logic [1:0]  w_cnt32;
    logic        w_rdy64, w_vld64, w_err64;
    logic [63:0] w_imm64;
    logic [1:0]  w_cnt64;

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    logic [64:0] q32[$];
    logic [64:0] q64[$];

    typedef struct {
        logic [2:0]  src;
        logic [31:0] ins;
        logic [63:0] e32;
        logic [63:0] e64;
        logic        err;
    } vec_t;
    vec_t vecs[8];

    imm_gen_stage #(.XLEN(32), .DEPTH(2)) u_dut32 (
        .clk(clk), .rstn(rstn), .flush(flush), .in_valid(in_valid), .in_ready(w_rdy32),
        .imm_src(imm_src), .instr(ins[31:7]), .out_valid(w_vld32), .out_ready(out_ready),
        .imm_ext(w_imm32), .imm_err(w_err32), .count(w_cnt32)
    );

    imm_gen_stage #(.XLEN(64), .DEPTH(3)) u_dut64 (
        .clk(clk), .rstn(rstn), .flush(flush), .in_valid(in_valid), .in_ready(w_rdy64),
        .imm_src(imm_src), .instr(ins[31:7]), .out_valid(w_vld64), .out_ready(out_ready),
        .imm_ext(w_imm64), .imm_err(w_err64), .count(w_cnt64)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Two's-complement reading of a bits-wide field
    function automatic longint sval(input longint field, input int bits);
        longint half;
        half = longint'(1) <<< (bits - 1);
        return (field >= half) ? field - (half * 2) : field;
    endfunction

    function automatic logic [63:0] ref_imm(input logic [2:0] src, input logic [31:0] i, input int xlen);
        longint v;
        case (src)
            3'd0:    v = sval(longint'(i[31:20]), 12);
            3'd1:    v = sval(longint'({i[31:25], i[11:7]}), 12);
            3'd2:    v = sval(longint'({i[31], i[7], i[30:25], i[11:8], 1'b0}), 13);
            3'd3:    v = sval(longint'(i[31:12]) * 4096, 32);
            3'd4:    v = sval(longint'({i[31], i[19:12], i[20], i[30:21], 1'b0}), 21);
            3'd5:    v = (xlen == 64) ? longint'(i[25:20]) : longint'(i[24:20]);
            3'd6:    v = longint'(i[19:15]);
            default: v = 0;
        endcase
        return (xlen == 32) ? (v & 64'hFFFF_FFFF) : v;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference queues: one entry per accepted instruction, in order
    always @(posedge clk) begin
        bit p32, o32, p64, o64;
        if (!rstn || flush) begin
            q32.delete();
            q64.delete();
        end else begin
            p32 = in_valid && (q32.size() < 2);
            o32 = out_ready && (q32.size() > 0);
            p64 = in_valid && (q64.size() < 3);
            o64 = out_ready && (q64.size() > 0);
            if (o32) void'(q32.pop_front());
            if (o64) void'(q64.pop_front());
            if (p32) q32.push_back({imm_src == 3'd7, ref_imm(imm_src, ins, 32)});
            if (p64) q64.push_back({imm_src == 3'd7, ref_imm(imm_src, ins, 64)});
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("sb_cnt32", w_cnt32, q32.size());
            check("sb_rdy32", w_rdy32, q32.size() < 2);
            check("sb_vld32", w_vld32, q32.size() != 0);
            if (q32.size() != 0) begin
                check("sb_imm32", w_imm32, q32[0][63:0]);
                check("sb_err32", w_err32, q32[0][64]);
            end
            check("sb_cnt64", w_cnt64, q64.size());
            check("sb_rdy64", w_rdy64, q64.size() < 3);
            check("sb_vld64", w_vld64, q64.size() != 0);
            if (q64.size() != 0) begin
                check("sb_imm64", w_imm64, q64[0][63:0]);
                check("sb_err64", w_err64, q64[0][64]);
            end
        end
    end

    initial begin
        logic [31:0] ia, ib, ic;
        vecs[0] = '{3'd0, 32'hFFF00093, 64'hFFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0};
        vecs[1] = '{3'd1, 32'hFE20AE23, 64'hFFFF_FFFC, 64'hFFFF_FFFF_FFFF_FFFC, 1'b0};
        vecs[2] = '{3'd2, 32'hFE000CE3, 64'hFFFF_FFF8, 64'hFFFF_FFFF_FFFF_FFF8, 1'b0};
        vecs[3] = '{3'd3, 32'h123450B7, 64'h1234_5000, 64'h0000_0000_1234_5000, 1'b0};
        vecs[4] = '{3'd4, 32'hFFDFF06F, 64'hFFFF_FFFC, 64'hFFFF_FFFF_FFFF_FFFC, 1'b0};
        vecs[5] = '{3'd5, 32'h03F00013, 64'h1F,        64'h3F,                  1'b0};
        vecs[6] = '{3'd6, 32'h000F8073, 64'h1F,        64'h1F,                  1'b0};
        vecs[7] = '{3'd7, 32'hFFFFFFFF, 64'h0,         64'h0,                   1'b1};

        rstn = 1'b0; flush = 1'b0; in_valid = 1'b0; imm_src = 3'd0; ins = '0; out_ready = 1'b0;
        tick();
        tick();
        check("rst_vld32", w_vld32, 1'b0);
        check("rst_rdy32", w_rdy32, 1'b1);
        check("rst_imm32", w_imm32, 32'h0);
        check("rst_err32", w_err32, 1'b0);
        check("rst_cnt32", w_cnt32, 2'd0);
        check("rst_vld64", w_vld64, 1'b0);
        check("rst_imm64", w_imm64, 64'h0);
        rstn = 1'b1;
        chk_en = 1'b1;

        // Formats: one entry at a time, visible exactly one cycle after acceptance
        out_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            in_valid = 1'b1; imm_src = vecs[k].src; ins = vecs[k].ins;
            tick();
            in_valid = 1'b0;
            check("vec_vld32", w_vld32, 1'b1);
            check("vec_imm32", w_imm32, vecs[k].e32);
            check("vec_err32", w_err32, vecs[k].err);
            check("vec_imm64", w_imm64, vecs[k].e64);
            check("vec_err64", w_err64, vecs[k].err);
            tick();
            check("vec_drain32", w_vld32, 1'b0);
        end

        // Backpressure: third push refused by the 2-deep instance
        ia = 32'h00100093; ib = 32'h00200093; ic = 32'h00300093;
        out_ready = 1'b0; in_valid = 1'b1; imm_src = 3'd0;
        ins = ia; tick();
        ins = ib; tick();
        ins = ic; tick();
        in_valid = 1'b0;
        check("bp_cnt32", w_cnt32, 2'd2);
        check("bp_rdy32", w_rdy32, 1'b0);
        check("bp_head32", w_imm32, 32'd1);
        out_ready = 1'b1;
        tick();
        check("bp_second32", w_imm32, 32'd2);
        tick();
        check("bp_empty32", w_vld32, 1'b0);
        in_valid = 1'b1; ins = ic;
        tick();
        in_valid = 1'b0;
        check("bp_third32", w_imm32, 32'd3);
        repeat (4) tick();

        // Streaming with wrap-around
        out_ready = 1'b1; in_valid = 1'b1;
        for (int k = 0; k < 20; k++) begin
            imm_src = 3'($urandom_range(0, 6));
            ins = $urandom();
            tick();
            check("stream_cnt32", w_cnt32, 2'd1);
            check("stream_cnt64", w_cnt64, 2'd1);
        end
        in_valid = 1'b0;
        tick();

        // Flush with two entries buffered plus a push in the same cycle
        out_ready = 1'b0; in_valid = 1'b1; imm_src = 3'd0;
        ins = 32'h00500093; tick();
        ins = 32'h00600093; tick();
        check("fl_pre_cnt32", w_cnt32, 2'd2);
        flush = 1'b1; ins = 32'h00700093;
        tick();
        flush = 1'b0; in_valid = 1'b0;
        check("fl_cnt32", w_cnt32, 2'd0);
        check("fl_vld32", w_vld32, 1'b0);
        check("fl_cnt64", w_cnt64, 2'd0);
        out_ready = 1'b1;
        tick();
        tick();
        check("fl_gone32", w_vld32, 1'b0);
        check("fl_gone64", w_vld64, 1'b0);

        // Reset in the middle of operation
        out_ready = 1'b0; in_valid = 1'b1; imm_src = 3'd0; ins = 32'hFFF00093;
        tick();
        in_valid = 1'b0;
        check("mr_cnt32", w_cnt32, 2'd1);
        rstn = 1'b0;
        tick();
        rstn = 1'b1;
        check("mr_vld32", w_vld32, 1'b0);
        check("mr_rdy32", w_rdy32, 1'b1);
        check("mr_imm32", w_imm32, 32'h0);
        check("mr_err32", w_err32, 1'b0);
        check("mr_imm64", w_imm64, 64'h0);
        check("mr_err64", w_err64, 1'b0);

        // Randomised traffic against the reference queues
        for (int k = 0; k < 400; k++) begin
            in_valid  = 1'($urandom_range(0, 1));
            out_ready = ($urandom_range(0, 3) != 0);
            imm_src   = 3'($urandom_range(0, 7));
            ins       = $urandom();
            flush     = ($urandom_range(0, 31) == 0);
            tick();
        end
        flush = 1'b0; in_valid = 1'b0;
        tick();
        chk_en = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/imm_gen_stage.md
Name: imm_gen_stage

Overview:
Parametrised, buffered immediate generator for the decode stage of the RV core. It covers all RV32I/RV64I immediate formats (I, S, B, U, J), plus the shift-amount and CSR zimm forms, and sign- or zero-extends each to XLEN. Results are queued in a small FIFO with valid/ready handshakes on both sides, so decode stalls and flushes are decoupled from execute. Illegal selectors are flagged rather than producing X.

Parameters:
XLEN, 32, datapath width; legal values are 32 or 64.
DEPTH, 2, number of FIFO entries; legal values are 2 to 8.

Ports:
clk  input  1  clock; all state updates on the rising edge.
rstn  input  1  synchronous, active-low reset.
flush  input  1  synchronous clear of all buffered entries.
in_valid  input  1  instr/imm_src are valid.
in_ready  output  1  block can accept an entry this cycle.
imm_src  input  3  format: 0=I, 1=S, 2=B, 3=U, 4=J, 5=SHAMT, 6=ZIMM, 7=illegal.
instr  input  25  instruction bits [31:7].
out_valid  output  1  head entry is valid.
out_ready  input  1  consumer accepts the head entry.
imm_ext  output  XLEN  immediate at the head entry.
imm_err  output  1  head entry came from an illegal imm_src.
count  output  $clog2(DEPTH+1)  current occupancy.

Behaviour:
- Reset (rstn=0 at a clock edge) sets count=0, rd/wr pointers=0, out_valid=0, in_ready=1, imm_ext=0, imm_err=0. Reset takes priority over flush and over both handshakes.
- Sign extension copies instr[31] up to bit XLEN-1.
- Format encodings:
  - I: sext(instr[31:20]).
  - S: sext({instr[31:25], instr[11:7]}).
  - B: sext({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}).
  - U: sext({instr[31:12], 12'b0}); for XLEN=32 this is exactly that value.
  - J: sext({instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}).
  - SHAMT: zero-extended instr[24:20] when XLEN=32, instr[25:20] when XLEN=64.
  - ZIMM: zero-extended instr[19:15].
  - 7 (illegal): imm_ext=0, imm_err=1. All other codes give imm_err=0.
- Extension is combinational at the input; the result is written into the FIFO. No output is ever X.
- Push occurs when in_valid && in_ready. Pop occurs when out_valid && out_ready.
- in_ready = (count != DEPTH). It depends only on state and has no combinational path from out_ready.
- out_valid = (count != 0). imm_ext and imm_err show the head entry and are registered outputs of FIFO storage.
- Latency: an accepted entry appears at the output the cycle after acceptance. There is no bypass.
- Full (count=DEPTH): in_ready=0 and input is ignored. A pop in that cycle frees a slot, but in_ready rises only the next cycle.
- Empty: out_valid=0, out_ready is ignored, and imm_ext/imm_err hold their last driven values. The bench must not check them while out_valid=0.
- Simultaneous push and pop when 0 < count < DEPTH: count is unchanged, both pointers advance, and FIFO order is preserved.
- Pointer wrap-around: pointers wrap modulo DEPTH, including non-power-of-2 depths.
- While out_valid=1 and out_ready=0, imm_ext and imm_err stay stable.
- flush=1: next cycle count=0, pointers=0, out_valid=0. Any push or pop in the flush cycle is discarded.
- Reset during operation: all entries are discarded, same state as the reset values above.

Test Plan:
- Formats, XLEN=32, out_ready=1, one entry at a time:
  - I, 0xFFF00093 -> imm_ext=0xFFFFFFFF.
  - S, 0xFE20AE23 -> 0xFFFFFFFC.
  - B, 0xFE000CE3 -> 0xFFFFFFF8.
  - U, 0x123450B7 -> 0x12345000.
  - J, 0xFFDFF06F -> 0xFFFFFFFC.
  - Each appears exactly 1 cycle after acceptance with imm_err=0.
- XLEN=64 special forms:
  - SHAMT, instr[25:20]=6'h3F -> 0x000000000000003F.
  - ZIMM, instr[19:15]=5'h1F -> 0x1F.
  - I, 0xFFF00093 -> 0xFFFFFFFFFFFFFFFF.
  - imm_src=7 -> imm_ext=0, imm_err=1.
- Backpressure, DEPTH=2: hold out_ready=0 and push 3 entries -> count=2, in_ready=0, third entry not accepted. Then release out_ready=1 -> first two entries emitted in order, then the third after it is re-presented.
- Streaming: in_valid=1 and out_ready=1 continuously for 20 entries, including wrap-around -> one output per cycle after the first, order preserved, count stays at 1.
- Flush with count=2 together with an in_valid push -> next cycle count=0 and out_valid=0; the pushed entry never appears.
- Reset asserted with count=1 -> next cycle out_valid=0, in_ready=1, imm_ext=0, imm_err=0.
